pb_debounce: RTL and testbench

Debounces one raw pushbutton or slide-switch input for the PicoBlaze SoC and produces a clean level plus single-cycle edge ticks. It sits directly upstream of the 1-bit capture registers and the processor input port logic. Those stages see exactly one event per physical press or release, and never a metastable or bouncing value. One instance is used per board input.

---
 rtl/pb_debounce.sv | 104 ++++++++++
 tb/tb_pb_debounce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce.sv
// Pushbutton/switch debouncer: two-flop synchronizer, stability counter and a four-state FSM
// producing a clean level plus one-clock rise/fall ticks.
module pb_debounce #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  typedef enum logic [1:0] {
    StLow,
    StWaitHigh,
    StHigh,
    StWaitLow
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync_0;
  logic             r_sync_1;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_0 <= 1'b0;
      r_sync_1 <= 1'b0;
      r_state  <= StLow;
      r_count  <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync_0 <= pb_in;
      r_sync_1 <= r_sync_0;
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // Counter is cleared on WAIT entry and leaves WAIT at LastCnt, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      StLow: begin
        if (r_sync_1) begin
          w_state_nxt = StWaitHigh;
          w_count_nxt = '0;
        end
      end
      StWaitHigh: begin
        if (!r_sync_1) begin
          w_state_nxt = StLow;
        end else if (r_count == LastCnt) begin
          w_state_nxt = StHigh;
          w_rise_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      StHigh: begin
        if (!r_sync_1) begin
          w_state_nxt = StWaitLow;
          w_count_nxt = '0;
        end
      end
      StWaitLow: begin
        if (r_sync_1) begin
          w_state_nxt = StHigh;
        end else if (r_count == LastCnt) begin
          w_state_nxt = StLow;
          w_fall_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = StLow;
        w_count_nxt = '0;
      end
    endcase
  end

  // Level is high in HIGH and while a release is still being qualified.
  assign db_level  = (r_state == StHigh) || (r_state == StWaitLow);
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: directed vector table and hand sequences on a STABLE_CYCLES=4 instance,
// plus random bouncing input checked on both instances against a run-length reference model.
module tb_pb_debounce;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pb_in = 1'b0;
  logic db_a, rise_a, fall_a;
  logic db_b, rise_b, fall_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pb_debounce #(.STABLE_CYCLES(4), .CNT_W(20)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .pb_in    (pb_in),
    .db_level (db_a),
    .rise_tick(rise_a),
    .fall_tick(fall_a)
  );

  // Counter width exactly fits: 2^3 == 8.
  pb_debounce #(.STABLE_CYCLES(8), .CNT_W(3)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .pb_in    (pb_in),
    .db_level (db_b),
    .rise_tick(rise_b),
    .fall_tick(fall_b)
  );

  // Reference: a change is accepted once the synchronized input has disagreed with the current
  // level for STABLE_CYCLES+1 consecutive edges; the synchronizer is a two-sample delay.
  int       m_s[2] = '{4, 8};
  logic [1:0] m_hist[2];
  logic     m_lvl[2];
  logic     m_rise[2];
  logic     m_fall[2];
  int       m_run[2];

  task automatic model_upd(input logic rst, input logic pb);
    for (int k = 0; k < 2; k++) begin
      logic seen;
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (rst) begin
        m_hist[k] = 2'b00;
        m_lvl[k]  = 1'b0;
        m_run[k]  = 0;
      end else begin
        seen      = m_hist[k][1];
        m_hist[k] = {m_hist[k][0], pb};
        if (seen != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == m_s[k] + 1) begin
            m_lvl[k]  = seen;
            m_rise[k] = seen;
            m_fall[k] = !seen;
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs, take one edge, then compare both instances against the model.
  task automatic step(input logic rst, input logic pb);
    reset = rst;
    pb_in = pb;
    @(posedge clk);
    model_upd(rst, pb);
    #1;
    chk("mdl_a_level", db_a, m_lvl[0]);
    chk("mdl_a_rise", rise_a, m_rise[0]);
    chk("mdl_a_fall", fall_a, m_fall[0]);
    chk("mdl_b_level", db_b, m_lvl[1]);
    chk("mdl_b_rise", rise_b, m_rise[1]);
    chk("mdl_b_fall", fall_b, m_fall[1]);
    chk("a_tick_excl", rise_a & fall_a, 1'b0);
  endtask

  task automatic step_exp(input string nm, input logic rst, input logic pb,
                          input logic lvl, input logic rs, input logic fl);
    step(rst, pb);
    chk({nm, "_level"}, db_a, lvl);
    chk({nm, "_rise"}, rise_a, rs);
    chk({nm, "_fall"}, fall_a, fl);
  endtask

  typedef struct {
    logic rst;
    logic pb;
    int   n;
    logic lvl;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic p, input int n,
                     input logic l, input logic ri, input logic fa);
    vec_t v;
    v.rst = r; v.pb = p; v.n = n; v.lvl = l; v.rise = ri; v.fall = fa;
    vecs.push_back(v);
  endtask

  initial begin
    logic rnd_pb;
    int   run_left;

    // Reset priority with pb held high, then normal acceptance at E6.
    add(1, 1, 3, 0, 0, 0);
    add(0, 1, 6, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 2, 1, 0, 0);
    // Clean release, press held 20 clocks, release.
    add(0, 0, 6, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 4, 0, 0, 0);
    add(0, 1, 6, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 13, 1, 0, 0);
    add(0, 0, 6, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 3, 0, 0, 0);
    add(0, 1, 6, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 3, 1, 0, 0);
    // Glitches while HIGH: 2 and 4 clocks low are rejected.
    add(0, 0, 2, 1, 0, 0);
    add(0, 1, 8, 1, 0, 0);
    add(0, 0, 4, 1, 0, 0);
    add(0, 1, 8, 1, 0, 0);
    // Minimum accepted low (5 clocks), then rise detection starts right after the fall tick.
    add(0, 0, 5, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 1);
    add(0, 1, 4, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 2, 1, 0, 0);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        step_exp($sformatf("tbl%0d", i), vecs[i].rst, vecs[i].pb,
                 vecs[i].lvl, vecs[i].rise, vecs[i].fall);
      end
    end

    // Bounce: 3 high / 1 low five times, then hold high.
    step_exp("bnc_rst", 1, 0, 0, 0, 0);
    step_exp("bnc_rst", 1, 0, 0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 3; j++) step_exp("bnc_hi", 0, 1, 0, 0, 0);
      step_exp("bnc_lo", 0, 0, 0, 0, 0);
    end
    for (int j = 0; j < 6; j++) step_exp("bnc_wait", 0, 1, 0, 0, 0);
    step_exp("bnc_rise", 0, 1, 1, 1, 0);
    step_exp("bnc_hold", 0, 1, 1, 0, 0);

    // Reset mid-WAIT_HIGH (count=2), then a normal press.
    step_exp("rmw_rst", 1, 0, 0, 0, 0);
    step_exp("rmw_rst", 1, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) step_exp("rmw_pre", 0, 1, 0, 0, 0);
    step_exp("rmw_hit", 1, 1, 0, 0, 0);
    for (int j = 0; j < 6; j++) step_exp("rmw_wait", 0, 1, 0, 0, 0);
    step_exp("rmw_rise", 0, 1, 1, 1, 0);
    step_exp("rmw_hold", 0, 1, 1, 0, 0);

    // Reset on the very edge a rise tick is due: the tick is dropped.
    step_exp("rtk_rst", 1, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++) step_exp("rtk_pre", 0, 1, 0, 0, 0);
    step_exp("rtk_hit", 1, 1, 0, 0, 0);
    step_exp("rtk_post", 0, 1, 0, 0, 0);

    // Random bouncing input with occasional reset, checked only against the model.
    rnd_pb   = 1'b0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        rnd_pb   = ~rnd_pb;
        run_left = int'($urandom_range(1, 14));
      end
      run_left--;
      step(($urandom_range(0, 299) == 0), rnd_pb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
